// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears on rst.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Load-use stall, taken-branch flush and data-memory wait sequencing for the
// 5-stage pipeline, with saturating stall/flush statistics.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_ifid,
    input  logic [4:0]       rt_ifid,
    input  logic             uses_rt_ifid,
    input  logic             mem_read_idex,
    input  logic [4:0]       rt_idex,
    input  logic             branch_taken,
    input  logic             mem_req_exmem,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [15:0] WAIT_MAX = 16'(WAIT_LIMIT);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt, wait_d;
    logic        load_use, mem_wait;
    logic        hold, decode;

    assign load_use = mem_read_idex && (rt_idex != REG_ZERO) &&
                      ((rt_idex == rs_ifid) || (uses_rt_ifid && (rt_idex == rt_ifid)));
    assign mem_wait = mem_req_exmem && !mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_d;
        end
    end

    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_cnt;
        hold         = 1'b0;
        decode       = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        pipe_hold    = 1'b0;
        memwb_bubble = 1'b0;
        mem_timeout  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    hold    = 1'b1;
                    state_d = ST_MEM_WAIT;
                    wait_d  = 16'd1;
                end else begin
                    decode = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    decode  = 1'b1;
                    state_d = ST_RUN;
                    wait_d  = '0;
                end else if (wait_cnt == WAIT_MAX) begin
                    hold    = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    hold   = 1'b1;
                    wait_d = wait_cnt + 16'd1;
                end
            end
            ST_FAULT: begin
                hold        = 1'b1;
                mem_timeout = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase

        // While held, branch/load-use sources are frozen and re-evaluated on release.
        if (hold) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            pipe_hold    = 1'b1;
            memwb_bubble = 1'b1;
        end else if (decode) begin
            if (branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    assign state = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   ((state_q != ST_FAULT) && !pc_write),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ifid_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench: a short-limit/narrow-counter instance (a) beside a default instance (b).
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs_ifid, rt_ifid, rt_idex;
    logic       uses_rt_ifid, mem_read_idex, branch_taken, mem_req_exmem, mem_ready;

    logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_flush;
    logic        a_pipe_hold, a_memwb_bubble, a_mem_timeout;
    logic [1:0]  a_state;
    logic [3:0]  a_stall_count, a_flush_count;
    logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_flush;
    logic        b_pipe_hold, b_memwb_bubble, b_mem_timeout;
    logic [1:0]  b_state;
    logic [15:0] b_stall_count, b_flush_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_controller #(.WAIT_LIMIT(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .rs_ifid(rs_ifid), .rt_ifid(rt_ifid),
        .uses_rt_ifid(uses_rt_ifid), .mem_read_idex(mem_read_idex), .rt_idex(rt_idex),
        .branch_taken(branch_taken), .mem_req_exmem(mem_req_exmem), .mem_ready(mem_ready),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
        .idex_flush(a_idex_flush), .pipe_hold(a_pipe_hold), .memwb_bubble(a_memwb_bubble),
        .mem_timeout(a_mem_timeout), .state(a_state),
        .stall_count(a_stall_count), .flush_count(a_flush_count)
    );

    hazard_controller dut_b (
        .clk(clk), .rst(rst), .rs_ifid(rs_ifid), .rt_ifid(rt_ifid),
        .uses_rt_ifid(uses_rt_ifid), .mem_read_idex(mem_read_idex), .rt_idex(rt_idex),
        .branch_taken(branch_taken), .mem_req_exmem(mem_req_exmem), .mem_ready(mem_ready),
        .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
        .idex_flush(b_idex_flush), .pipe_hold(b_pipe_hold), .memwb_bubble(b_memwb_bubble),
        .mem_timeout(b_mem_timeout), .state(b_state),
        .stall_count(b_stall_count), .flush_count(b_flush_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inputs change at posedge+1; combinational checks follow at posedge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_ifid = 5'd0; rt_ifid = 5'd0; rt_idex = 5'd0;
        uses_rt_ifid = 1'b0; mem_read_idex = 1'b0; branch_taken = 1'b0;
        mem_req_exmem = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #3;
        check("rst_state", 32'(a_state), 0);
        check("rst_pc_write", 32'(a_pc_write), 1);
        check("rst_stall_cnt", 32'(a_stall_count), 0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic load_use_vec(input logic [4:0] rs, input logic [4:0] rt,
                                input logic urt, input logic [4:0] rtx);
        rs_ifid = rs; rt_ifid = rt; uses_rt_ifid = urt; rt_idex = rtx; mem_read_idex = 1'b1;
    endtask

    initial begin
        idle();
        #2;
        do_reset();
        check("rst_flush_cnt", 32'(a_flush_count), 0);
        check("rst_timeout", 32'(a_mem_timeout), 0);
        check("rst_idex_flush", 32'(a_idex_flush), 0);

        // Load-use on rs
        load_use_vec(5'd3, 5'd0, 1'b0, 5'd3);
        #1;
        check("lu_pc_write", 32'(a_pc_write), 0);
        check("lu_ifid_write", 32'(a_ifid_write), 0);
        check("lu_idex_flush", 32'(a_idex_flush), 1);
        check("lu_ifid_flush", 32'(a_ifid_flush), 0);
        tick();
        idle();
        #1;
        check("lu_stall_cnt", 32'(a_stall_count), 1);
        check("lu_release_pc", 32'(a_pc_write), 1);

        // Load-use on rt when rt is a source
        load_use_vec(5'd2, 5'd7, 1'b1, 5'd7);
        #1;
        check("lu_rt_pc_write", 32'(a_pc_write), 0);
        tick();
        // Load into $0 never stalls
        load_use_vec(5'd0, 5'd0, 1'b1, 5'd0);
        #1;
        check("lu_r0_pc_write", 32'(a_pc_write), 1);
        check("lu_r0_idex_flush", 32'(a_idex_flush), 0);
        tick();
        // rt matches but is not read
        load_use_vec(5'd1, 5'd5, 1'b0, 5'd5);
        #1;
        check("lu_nort_pc_write", 32'(a_pc_write), 1);
        tick();
        // Non-load producer: forwarding covers it
        load_use_vec(5'd3, 5'd0, 1'b0, 5'd3);
        mem_read_idex = 1'b0;
        #1;
        check("nonload_pc_write", 32'(a_pc_write), 1);
        tick();
        idle();
        #1;
        check("lu_mix_stall_cnt", 32'(a_stall_count), 2);

        // Branch beats load-use
        load_use_vec(5'd3, 5'd0, 1'b0, 5'd3);
        branch_taken = 1'b1;
        #1;
        check("br_ifid_flush", 32'(a_ifid_flush), 1);
        check("br_idex_flush", 32'(a_idex_flush), 1);
        check("br_pc_write", 32'(a_pc_write), 1);
        check("br_ifid_write", 32'(a_ifid_write), 1);
        tick();
        idle();
        #1;
        check("br_flush_cnt", 32'(a_flush_count), 1);
        check("br_stall_cnt", 32'(a_stall_count), 2);

        // Memory wait of 3 cycles with a pending branch: hold first, flush on release
        do_reset();
        mem_req_exmem = 1'b1;
        branch_taken  = 1'b1;
        #1;
        check("mw_state_first", 32'(a_state), 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mw_hold_%0d", i), 32'(a_pipe_hold), 1);
            check($sformatf("mw_bubble_%0d", i), 32'(a_memwb_bubble), 1);
            check($sformatf("mw_pc_%0d", i), 32'(a_pc_write), 0);
            check($sformatf("mw_noflush_%0d", i), 32'(a_ifid_flush), 0);
            tick();
            #1;
            check($sformatf("mw_state_%0d", i), 32'(a_state), 1);
        end
        mem_ready = 1'b1;
        #1;
        check("mw_rel_hold", 32'(a_pipe_hold), 0);
        check("mw_rel_pc", 32'(a_pc_write), 1);
        check("mw_rel_ifid_flush", 32'(a_ifid_flush), 1);
        check("mw_rel_idex_flush", 32'(a_idex_flush), 1);
        tick();
        idle();
        #1;
        check("mw_after_state", 32'(a_state), 0);
        check("mw_stall_cnt", 32'(a_stall_count), 3);
        check("mw_flush_cnt", 32'(a_flush_count), 1);
        check("mw_b_stall_cnt", 32'(b_stall_count), 3);

        // Timeout: instance a (limit 4) faults after the 5th edge, b (limit 16) keeps waiting
        do_reset();
        mem_req_exmem = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #1;
        check("to_state_4", 32'(a_state), 1);
        check("to_timeout_4", 32'(a_mem_timeout), 0);
        tick();
        #1;
        check("to_state_5", 32'(a_state), 2);
        check("to_timeout_5", 32'(a_mem_timeout), 1);
        check("to_b_state_5", 32'(b_state), 1);
        check("to_stall_cnt", 32'(a_stall_count), 5);
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #1;
        check("to_stuck_state", 32'(a_state), 2);
        check("to_stuck_pc", 32'(a_pc_write), 0);
        check("to_stuck_hold", 32'(a_pipe_hold), 1);
        check("to_fault_no_count", 32'(a_stall_count), 5);
        #2;
        rst = 1'b1;
        #1;
        check("to_rst_state", 32'(a_state), 0);
        check("to_rst_timeout", 32'(a_mem_timeout), 0);
        check("to_rst_pc", 32'(a_pc_write), 1);
        tick();
        rst = 1'b0;
        idle();
        #1;

        // Saturation: 20 load-use cycles
        load_use_vec(5'd9, 5'd0, 1'b0, 5'd9);
        for (int i = 0; i < 20; i++) tick();
        idle();
        #1;
        check("sat_a_stall_cnt", 32'(a_stall_count), 15);
        check("sat_b_stall_cnt", 32'(b_stall_count), 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
